score_display: RTL
==================

# score_display

Downstream consumer of `snake_length`'s 8-bit `num` snake-length count. Converts the binary count to three BCD digits with a sequential double-dabble converter. Drives a 4-digit, common-anode, time-multiplexed 7-segment display. Sits between `snake_length` and the board's segment/digit-select pins. Shows a dash pattern while the game is idle.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥ 2.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low; one clock domain, no other clock.
- `num`  in  8  binary length count from `snake_length`, 0..255.
- `game_status`  in  2  game state; 2'b00 = idle/reset state, any other value = game active.
- `seg`  out  8  segment drive, active-low; bit0=a … bit6=g, bit7=dp.
- `sel`  out  4  digit enable, active-low one-hot; bit0 = ones (rightmost), bit3 = leftmost.

## Operation
- Internal state:
  - `shown_bin[7:0]`: last value converted.
  - Converter FSM with states IDLE, SHIFT, DONE.
  - 20-bit shift register: 12 BCD bits plus 8 binary bits.
  - 3-bit shift counter.
  - Digit registers `hun`, `ten`, `one` (4 bits each).
  - Scan divider (counts 0..SCAN_DIV-1).
  - 2-bit scan index.
- Converter FSM:
  - IDLE, when `num != shown_bin`:
    - load shift register = {12'b0, num};
    - `shown_bin <= num`;
    - counter <= 0;
    - go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT, each cycle: apply the add-3 correction (+3 to each BCD nibble ≥ 5), then shift left by 1. After the 8th shift, go to DONE.
  - DONE: `hun/ten/one <= shift register[19:8]`; go to IDLE.
- `num` is sampled only in IDLE. A change during SHIFT/DONE is ignored until the FSM returns to IDLE. IDLE then sees the mismatch and reconverts; the final value is never lost.
- Digit content:
  - When `game_status == 2'b00`: all four digits show dash (8'hBF).
  - Otherwise:
    - digit3 is blank (8'hFF);
    - digit2 shows `hun`, blanked if zero;
    - digit1 shows `ten`, blanked if `hun` and `ten` are both zero;
    - digit0 always shows `one`.
- Segment codes, 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. dp is always 1 (off).
- Scan:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, the scan index increments 0→1→2→3→0.
  - Index i selects digit i: `sel` = ~(1<<i).
- `seg` and `sel` are registered. Each cycle they load the code and enable for the current index and current digit content.

## Timing
- Reset (async assert): state IDLE, `shown_bin` = 0, digit regs = 0, divider = 0, index = 0, `seg` = 8'hFF, `sel` = 4'b1111.
- First active clock after reset release drives `sel` = 4'b1110 with the digit0 code.
- Conversion latency:
  - Mismatch detected at IDLE edge t.
  - Shifts occur at edges t+1..t+8.
  - Digit regs update at edge t+9.
  - `seg` reflects the new value at edge t+10 while digit0 is selected.
- Minimum spacing between two accepted `num` samples: 10 cycles.
- `game_status` change: affects `seg` one cycle later, with no conversion delay.
- Wrap 255→0 from upstream is treated as an ordinary change; the display reads "0".
- Reset mid-conversion aborts the conversion immediately. After release, the FSM reconverts if `num != 0`.
- Each digit stays selected for exactly SCAN_DIV cycles. Full refresh period = 4·SCAN_DIV cycles.

## Test plan
- Reset, then hold `num`=0, `game_status`=01, SCAN_DIV=4:
  - during reset: `seg`=FF, `sel`=1111;
  - after release: `sel` sequence 1110→1101→1011→0111, 4 cycles each;
  - `seg` values: C0, FF, FF, FF.
- `num` 0→123 with `game_status`=01:
  - digit regs read 1/2/3 exactly 9 cycles after the detection edge;
  - scan shows digit0=B0, digit1=A4, digit2=F9, digit3=FF.
- `num`=7: digit0=F8, digit1=FF, digit2=FF (leading-zero blanking). `num`=70: digit1=F8, digit0=C0, digit2=FF.
- `num` 10→11, changed 3 cycles after the first conversion starts:
  - digits first read 010;
  - after DONE→IDLE, a second conversion starts;
  - final digits read 011, `shown_bin`=11.
- `game_status`=00 with `num`=42: all four digit slots show BF. Switch to 01: digits show 2 (A4) and 4 (99), digit2 and digit3 blank.
- `num` 255→0: first shows 2/5/5 (A4, 92, 92), then C0 on digit0 with others blank. Assert `rst_n` mid-SHIFT: outputs immediately FF/1111, FSM in IDLE.

Source files
------------

// File: rtl/score_display.sv
// score_display
// Converts the 8-bit snake length into three BCD digits with a sequential
// double-dabble converter and scans them onto a 4-digit, common-anode,
// time-multiplexed 7-segment display. While the game is idle, every digit
// shows a dash.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   num          binary length count, 0..255
//   game_status  2'b00 = idle (dashes), anything else = game active
//   seg          segment drive, active-low, bit0=a .. bit6=g, bit7=dp
//   sel          digit enable, active-low one-hot, bit0 = rightmost digit
module score_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] num,
    input  logic [1:0] game_status,
    output logic [7:0] seg,
    output logic [3:0] sel
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    conv_state_t      state_q, state_d;
    logic [7:0]       shown_bin_q, shown_bin_d;
    logic [19:0]      sr_q, sr_d;
    logic [19:0]      sr_corr;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       hun_q, hun_d;
    logic [3:0]       ten_q, ten_d;
    logic [3:0]       one_q, one_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       sel_q, sel_d;

    // Active-low segment pattern for one decimal digit; dp stays off.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    always_comb begin
        sr_corr = sr_q;
        if (sr_q[11:8] >= 4'd5) begin
            sr_corr[11:8] = sr_q[11:8] + 4'd3;
        end
        if (sr_q[15:12] >= 4'd5) begin
            sr_corr[15:12] = sr_q[15:12] + 4'd3;
        end
        if (sr_q[19:16] >= 4'd5) begin
            sr_corr[19:16] = sr_q[19:16] + 4'd3;
        end
    end

    // Converter FSM. num is only looked at in IDLE; a change that arrives
    // mid-conversion is caught by the mismatch test on the next IDLE cycle.
    always_comb begin
        state_d     = state_q;
        shown_bin_d = shown_bin_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hun_d       = hun_q;
        ten_d       = ten_q;
        one_d       = one_q;
        case (state_q)
            IDLE: begin
                if (num != shown_bin_q) begin
                    sr_d        = {12'b0, num};
                    shown_bin_d = num;
                    cnt_d       = 3'd0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_corr << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hun_d   = sr_q[19:16];
                ten_d   = sr_q[15:12];
                one_d   = sr_q[11:8];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scan divider and digit index; the index advances on the divider's
    // terminal count so each digit is enabled for exactly SCAN_DIV cycles.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Segment/enable selection for the current index, with leading-zero
    // blanking on the hundreds and tens digits and dashes when idle.
    always_comb begin
        sel_d = ~(4'b0001 << idx_q);
        seg_d = 8'hFF;
        if (game_status == 2'b00) begin
            seg_d = 8'hBF;
        end else begin
            case (idx_q)
                2'd0: seg_d = seg_code(one_q);
                2'd1: seg_d = (hun_q == 4'd0 && ten_q == 4'd0) ? 8'hFF : seg_code(ten_q);
                2'd2: seg_d = (hun_q == 4'd0) ? 8'hFF : seg_code(hun_q);
                default: seg_d = 8'hFF;
            endcase
        end
    end

    // State register; reset aborts any conversion in flight and blanks
    // the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shown_bin_q <= 8'd0;
            sr_q        <= 20'd0;
            cnt_q       <= 3'd0;
            hun_q       <= 4'd0;
            ten_q       <= 4'd0;
            one_q       <= 4'd0;
            div_q       <= '0;
            idx_q       <= 2'd0;
            seg_q       <= 8'hFF;
            sel_q       <= 4'b1111;
        end else begin
            state_q     <= state_d;
            shown_bin_q <= shown_bin_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            hun_q       <= hun_d;
            ten_q       <= ten_d;
            one_q       <= one_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
        end
    end

    assign seg = seg_q;
    assign sel = sel_q;

endmodule
